// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU.
// Encodings 000..011 match the legacy 2-bit ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpOr  = 3'b010,
    OpAnd = 3'b011,
    OpXor = 3'b100,
    OpSlt = 3'b101,
    OpSll = 3'b110,
    OpSra = 3'b111
  } alu_op_e;

  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result plus {N, Z, C, V} flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_op_e          op;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic             carry;
  logic             ovf;

  assign op = alu_op_e'(sel);

  always_comb begin
    // SUB shares the adder as a + ~b + 1 so carry-out means "no borrow".
    is_sub = (op == OpSub);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt  = b[SHW-1:0];
    y      = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      OpAdd, OpSub: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OpOr:  y = a | b;
      OpAnd: y = a & b;
      OpXor: y = a ^ b;
      OpSlt: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSll: y = a << shamt;
      OpSra: y = $signed(a) >>> shamt;
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[FLG_N] = y[WIDTH-1];
    flags[FLG_Z] = (y == '0);
    flags[FLG_C] = carry;
    flags[FLG_V] = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds result and flags.
// Define ALU_ACC_EN to add an accumulator that can replace operand A (acc_sel).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_sel_q, s1_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;

  logic             s2_free;
  logic             accept;
  logic             move;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_y;
  logic [3:0]       core_flags;

  assign s2_free  = !out_valid_q || out_ready;
  assign move     = s1_valid_q && s2_free;
  // Held low during reset so nothing is captured while state is being cleared.
  assign in_ready = !rst && (!s1_valid_q || s2_free);
  assign accept   = in_valid && in_ready;

`ifdef ALU_ACC_EN
  logic             s1_acc_q, s1_acc_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    s1_acc_d = accept ? acc_sel : s1_acc_q;
    acc_d    = move ? core_y : acc_q;
  end

  // acc_q already reflects every earlier move, so chained beats need no bubble.
  assign core_a = s1_acc_q ? acc_q : s1_a_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_acc_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      s1_acc_q <= s1_acc_d;
      acc_q    <= acc_d;
    end
  end
`else
  logic unused_acc_sel;
  assign unused_acc_sel = acc_sel;
  assign core_a         = s1_a_q;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (move) begin
      s1_valid_d = 1'b0;
    end
    s1_a_d   = accept ? a : s1_a_q;
    s1_b_d   = accept ? b : s1_b_q;
    s1_sel_d = accept ? sel : s1_sel_q;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    flags_d     = flags_q;
    if (move) begin
      out_valid_d = 1'b1;
      y_d         = core_y;
      flags_d     = core_flags;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a    (core_a),
    .b    (s1_b_q),
    .sel  (s1_sel_q),
    .y    (core_y),
    .flags(core_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_sel_q    <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_sel_q    <= s1_sel_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8) with an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] sel;
  logic       acc_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic [3:0] flags;

  int vectors    = 0;
  int miscompares = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  got_q[$];
  logic        hold_pend;
  logic [7:0]  hold_y;
  logic [3:0]  hold_f;
  logic        last_accept;
`ifdef ALU_ACC_EN
  logic [7:0]  model_acc;
`endif

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] vy;
    logic [3:0] vf;
  } dvec_t;

  alu_pipe #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .acc_sel  (acc_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .flags    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {N, Z, C, V, y}.
  function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic [2:0] op);
    int ua, ub, sa, sb, r;
    logic c, v, n, z;
    logic [7:0] ry;
    ua = ma; ub = mb;
    sa = $signed(ma); sb = $signed(mb);
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      3'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r = ua - ub; c = (ua >= ub); v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r = ua | ub;
      3'd3: r = ua & ub;
      3'd4: r = ua ^ ub;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = ua << (ub % 8);
      default: r = sa >>> (ub % 8);
    endcase
    ry = r[7:0];
    n = ry[7];
    z = (ry == 8'h00);
    return {n, z, c, v, ry};
  endfunction

  // One clock of stimulus with scoreboard and hold-stability checks.
  task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [2:0] isel, input logic iacc, input logic ordy);
    logic [11:0] e;
    logic [7:0]  ea;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; sel = isel; acc_sel = iacc; out_ready = ordy;
    #1;
    if (hold_pend) begin
      vectors++;
      if (out_valid !== 1'b1 || y !== hold_y || flags !== hold_f) begin
        miscompares++;
        $display("FAIL hold_stable: got v=%b y=%h f=%b expected v=1 y=%h f=%b",
                 out_valid, y, flags, hold_y, hold_f);
      end
    end
    hold_pend = out_valid && !out_ready;
    hold_y = y;
    hold_f = flags;
    if (out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got y=%h f=%b expected no beat", y, flags);
      end else begin
        e = exp_q.pop_front();
        if ({flags, y} !== e) begin
          miscompares++;
          $display("FAIL result: got y=%h f=%b expected y=%h f=%b", y, flags, e[7:0], e[11:8]);
        end
      end
      got_q.push_back(y);
    end
    last_accept = in_valid && in_ready;
    if (last_accept) begin
      ea = ia;
`ifdef ALU_ACC_EN
      if (iacc) ea = model_acc;
`endif
      e = model(ea, ib, isel);
`ifdef ALU_ACC_EN
      model_acc = e[7:0];
`endif
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; acc_sel = 1'b0; out_ready = 1'b1;
    hold_pend = 1'b0; last_accept = 1'b0;
`ifdef ALU_ACC_EN
    model_acc = 8'h00;
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || y !== 8'h00 || flags !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b rdy=%b y=%h f=%b expected 0 0 00 0000",
               out_valid, in_ready, y, flags);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    dvec_t tv[10];
    tv[0] = {OpAdd, 8'h7F, 8'h01, 8'h80, 4'b1001};
    tv[1] = {OpSub, 8'h05, 8'h05, 8'h00, 4'b0110};
    tv[2] = {OpSub, 8'h03, 8'h05, 8'hFE, 4'b1000};
    tv[3] = {OpSra, 8'h80, 8'h03, 8'hF0, 4'b1000};
    tv[4] = {OpSll, 8'h81, 8'h09, 8'h02, 4'b0000};
    tv[5] = {OpSlt, 8'hFF, 8'h01, 8'h01, 4'b0000};
    tv[6] = {OpOr,  8'hA0, 8'h0A, 8'hAA, 4'b1000};
    tv[7] = {OpAnd, 8'hF0, 8'h0F, 8'h00, 4'b0100};
    tv[8] = {OpXor, 8'hFF, 8'h0F, 8'hF0, 4'b1000};
    tv[9] = {OpAdd, 8'hFF, 8'h01, 8'h00, 4'b0110};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = tv[i].va; b = tv[i].vb; sel = tv[i].op; acc_sel = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_early[%0d]: got out_valid=%b expected 0", i, out_valid);
      end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || y !== tv[i].vy || flags !== tv[i].vf) begin
        miscompares++;
        $display("FAIL directed[%0d]: got v=%b y=%h f=%b expected v=1 y=%h f=%b",
                 i, out_valid, y, flags, tv[i].vy, tv[i].vf);
      end
    end
    hold_pend = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   hi;
    int   runs;
    logic prev;
    hi = 0; runs = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b1);
        vectors++;
        if (!last_accept) begin
          miscompares++;
          $display("FAIL b2b_in_ready[%0d]: got 0 expected 1", i);
        end
      end else begin
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
      end
      if (out_valid && !prev) runs++;
      if (out_valid) hi++;
      prev = out_valid;
    end
    vectors++;
    if (hi != 8 || runs != 1) begin
      miscompares++;
      $display("FAIL b2b_out_valid: got %0d cycles in %0d runs expected 8 in 1", hi, runs);
    end
    drain(4);
  endtask

  task automatic test_backpressure();
    int acc_cnt;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b0);
      if (last_accept) acc_cnt++;
    end
    vectors++;
    if (acc_cnt != 2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure: got %0d accepted rdy=%b expected 2 rdy=0", acc_cnt, in_ready);
    end
    drain(6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
           1'($urandom), $urandom_range(0, 2) != 0);
    end
    drain(20);
  endtask

`ifdef ALU_ACC_EN
  task automatic test_acc();
    got_q.delete();
    step(1'b1, 8'h10, 8'h05, OpAdd, 1'b0, 1'b1);
    step(1'b1, 8'($urandom), 8'h01, OpAdd, 1'b1, 1'b1);
    step(1'b1, 8'($urandom), 8'h01, OpAdd, 1'b1, 1'b1);
    drain(4);
    vectors++;
    if (got_q.size() != 3 || got_q[0] !== 8'h15 || got_q[1] !== 8'h16 || got_q[2] !== 8'h17) begin
      miscompares++;
      $display("FAIL acc_chain: got %0d beats expected 15 16 17", got_q.size());
    end
  endtask
`endif

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b0);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || y !== 8'h00 || flags !== 4'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got v=%b rdy=%b y=%h f=%b expected 0 0 00 0000",
               out_valid, in_ready, y, flags);
    end
    exp_q.delete();
    hold_pend = 1'b0;
`ifdef ALU_ACC_EN
    model_acc = 8'h00;
`endif
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
`ifdef ALU_ACC_EN
    step(1'b1, 8'hAA, 8'h03, OpAdd, 1'b1, 1'b1);
`else
    step(1'b1, 8'h12, 8'h34, OpAdd, 1'b0, 1'b1);
`endif
    drain(5);
    vectors++;
`ifdef ALU_ACC_EN
    if (got_q.size() != 1 || got_q[0] !== 8'h03) begin
      miscompares++;
      $display("FAIL post_reset_acc: got %0d beats expected one beat y=03", got_q.size());
    end
`else
    if (got_q.size() != 1 || got_q[0] !== 8'h46) begin
      miscompares++;
      $display("FAIL post_reset_beat: got %0d beats expected one beat y=46", got_q.size());
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
`ifdef ALU_ACC_EN
    test_acc();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
